// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60 VGA: pixel/line counters with registered sync and active-video decode.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN; otherwise frame_cnt is tied to zero.
module vga_timing_gen #(
    parameter  int unsigned H_ACTIVE = 640,
    parameter  int unsigned H_FP     = 16,
    parameter  int unsigned H_SYNC   = 96,
    parameter  int unsigned H_BP     = 48,
    parameter  int unsigned V_ACTIVE = 480,
    parameter  int unsigned V_FP     = 10,
    parameter  int unsigned V_SYNC   = 2,
    parameter  int unsigned V_BP     = 33,
    localparam int unsigned CNT_W    = 10,
    localparam int unsigned FC_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pclk_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync,
    output logic             vsync,
    output logic             valid,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_cnt
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Counters are CNT_W bits wide, so neither raster dimension may exceed 2**CNT_W.
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_valid;
    logic             r_line_start;
    logic             r_frame_start;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_valid_nxt;
    logic             w_line_start_nxt;
    logic             w_frame_start_nxt;
    logic             w_adv;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_valid       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_h_cnt       <= w_h_nxt;
            r_v_cnt       <= w_v_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_valid       <= w_valid_nxt;
            r_line_start  <= w_line_start_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    // Next position plus decode of that same position, so levels never lag the counters.
    always_comb begin
        w_state_nxt       = r_state;
        w_h_nxt           = r_h_cnt;
        w_v_nxt           = r_v_cnt;
        w_hsync_nxt       = r_hsync;
        w_vsync_nxt       = r_vsync;
        w_valid_nxt       = r_valid;
        w_line_start_nxt  = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_adv             = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (pclk_en) begin
                    w_state_nxt       = S_RUN;
                    w_h_nxt           = '0;
                    w_v_nxt           = '0;
                    w_adv             = 1'b1;
                    w_line_start_nxt  = 1'b1;
                    w_frame_start_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (pclk_en) begin
                    w_adv = 1'b1;
                    if (r_h_cnt == H_LAST) begin
                        w_h_nxt          = '0;
                        w_line_start_nxt = 1'b1;
                        if (r_v_cnt == V_LAST) begin
                            w_v_nxt           = '0;
                            w_frame_start_nxt = 1'b1;
                        end else begin
                            w_v_nxt = r_v_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_h_nxt = r_h_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_adv) begin
            w_valid_nxt = (32'(w_h_nxt) < H_ACTIVE) && (32'(w_v_nxt) < V_ACTIVE);
            w_hsync_nxt = !((32'(w_h_nxt) >= HS_START) && (32'(w_h_nxt) < HS_END));
            w_vsync_nxt = !((32'(w_v_nxt) >= VS_START) && (32'(w_v_nxt) < VS_END));
        end
    end

    assign h_cnt       = r_h_cnt;
    assign v_cnt       = r_v_cnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign valid       = r_valid;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
    logic [FC_W-1:0] r_frame_cnt;
    logic            w_frame_wrap;

    // Only RUN-state wraps count; the IDLE->RUN entry also raises frame_start but is not a wrap.
    assign w_frame_wrap = w_frame_start_nxt && (r_state == S_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + FC_W'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: full-size instance for line-level checks,
// a shrunken-raster instance for frame-level and frame counter checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en_a = 1'b0;
    logic       en_b = 1'b0;
    logic [9:0] h_a, v_a, h_b, v_b;
    logic       hs_a, vs_a, vld_a, ls_a, fs_a;
    logic       hs_b, vs_b, vld_b, ls_b, fs_b;
    logic [7:0] fc_a, fc_b;

    vga_timing_gen u_dut (
        .clk(clk), .rst(rst), .pclk_en(en_a),
        .h_cnt(h_a), .v_cnt(v_a), .hsync(hs_a), .vsync(vs_a), .valid(vld_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    // Small raster: H 4+1+2+1 = 8, V 3+1+1+1 = 6, 48 pixels per frame.
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .clk(clk), .rst(rst), .pclk_en(en_b),
        .h_cnt(h_b), .v_cnt(v_b), .hsync(hs_b), .vsync(vs_b), .valid(vld_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Expected {valid, hsync, vsync} for a position; sync windows are [s0, s1).
    function automatic logic [2:0] dec(input int h, input int v, input int ha, input int hs0,
                                       input int hs1, input int va, input int vs0, input int vs1);
        logic vl, hs, vs;
        vl = (h < ha) && (v < va);
        hs = !((h >= hs0) && (h < hs1));
        vs = !((v >= vs0) && (v < vs1));
        return {vl, hs, vs};
    endfunction

    task automatic step_a(input logic en);
        @(negedge clk);
        en_a = en;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic en);
        @(negedge clk);
        en_b = en;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int eh, input int ev, input logic evl,
                           input logic ehs, input logic evs, input logic els, input logic efs);
        chk({tag, ".h_cnt"}, int'(h_a), eh);
        chk({tag, ".v_cnt"}, int'(v_a), ev);
        chk({tag, ".valid"}, int'(vld_a), int'(evl));
        chk({tag, ".hsync"}, int'(hs_a), int'(ehs));
        chk({tag, ".vsync"}, int'(vs_a), int'(evs));
        chk({tag, ".line_start"}, int'(ls_a), int'(els));
        chk({tag, ".frame_start"}, int'(fs_a), int'(efs));
        chk({tag, ".frame_cnt"}, int'(fc_a), 0);
    endtask

    typedef struct {
        logic en;
        int   h;
        int   v;
        logic vl;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } vec_t;

    vec_t tbl [7];

    int       mh, mv;
    logic [2:0] d;

    // Advance the full-size model by one pixel; returns line_start expectation.
    task automatic adv_a(output logic els, output logic efs);
        if (mh == 799) begin
            mh = 0;
            mv = (mv == 524) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        els = (mh == 0);
        efs = (mh == 0) && (mv == 0);
    endtask

    initial begin
        logic els, efs;
        int   ls_cnt, hs_low_cnt;

        tbl[0] = '{1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset held while pclk_en toggles: everything stays at reset values.
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step_a(1'(i % 2));
            check_a("in_reset", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        en_a = 1'b0;
        rst  = 1'b1;

        // Startup sequence from IDLE.
        for (int i = 0; i < 7; i++) begin
            step_a(tbl[i].en);
            check_a($sformatf("tbl%0d", i), tbl[i].h, tbl[i].v, tbl[i].vl, tbl[i].hs,
                    tbl[i].vs, tbl[i].ls, tbl[i].fs);
        end

        // Rest of line 0 with pclk_en every 4th clk, through the 799->0 wrap.
        mh = 3; mv = 0;
        ls_cnt = 0; hs_low_cnt = 0;
        for (int p = 0; p < 797; p++) begin
            for (int k = 0; k < 3; k++) begin
                step_a(1'b0);
                chk("line_hold.h_cnt", int'(h_a), mh);
                chk("line_hold.line_start", int'(ls_a), 0);
            end
            step_a(1'b1);
            adv_a(els, efs);
            d = dec(mh, mv, 640, 656, 752, 480, 490, 492);
            check_a("line0", mh, mv, d[2], d[1], d[0], els, efs);
            if (ls_a) ls_cnt++;
            if (!hs_a) hs_low_cnt++;
        end
        chk("line0.end_h", int'(h_a), 0);
        chk("line0.end_v", int'(v_a), 1);
        chk("line0.line_start_count", ls_cnt, 1);
        chk("line0.hsync_low_count", hs_low_cnt, 96);

        // Back-to-back pclk_en up to h=300, then a 50-clk stall.
        for (int p = 0; p < 300; p++) begin
            step_a(1'b1);
            adv_a(els, efs);
            d = dec(mh, mv, 640, 656, 752, 480, 490, 492);
            check_a("run300", mh, mv, d[2], d[1], d[0], els, efs);
        end
        for (int k = 0; k < 50; k++) begin
            step_a(1'b0);
            check_a("stall", 300, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        step_a(1'b1);
        adv_a(els, efs);
        check_a("after_stall", 301, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Move into the hsync window and reset between clock edges.
        for (int p = 0; p < 399; p++) begin
            step_a(1'b1);
            adv_a(els, efs);
        end
        d = dec(mh, mv, 640, 656, 752, 480, 490, 492);
        check_a("at700", 700, 1, d[2], d[1], d[0], 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_a("async_rst", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step_a(1'b1);
        check_a("async_rst_held", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        en_a = 1'b0;
        rst  = 1'b1;
        step_a(1'b0);
        check_a("restart_idle", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step_a(1'b1);
        check_a("restart_first", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step_a(1'b1);
        check_a("restart_second", 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        en_a = 1'b0;

        begin : small_frames
            logic started, en, sls, sfs, svl, shs, svs;
            int   sh, sv, wraps, pix_since, fc_exp, cyc;
            started = 1'b0; sh = 0; sv = 0; wraps = 0; pix_since = 0; fc_exp = 0; cyc = 0;
            while ((wraps < 257) && (cyc < 40000)) begin
                cyc++;
                en = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
                step_b(en);
                sls = 1'b0;
                sfs = 1'b0;
                if (en) begin
                    if (!started) begin
                        started = 1'b1;
                        sh = 0; sv = 0;
                        sls = 1'b1; sfs = 1'b1;
                    end else begin
                        if (sh == 7) begin
                            sh = 0;
                            sv = (sv == 5) ? 0 : sv + 1;
                        end else begin
                            sh = sh + 1;
                        end
                        sls = (sh == 0);
                        sfs = (sh == 0) && (sv == 0);
                        if (sfs) begin
                            wraps++;
`ifdef VGA_FRAME_CNT_EN
                            fc_exp = (fc_exp + 1) % 256;
`endif
                        end
                    end
                    pix_since++;
                    if (sfs) begin
                        if (wraps > 0) chk("small.frame_period", pix_since, 48);
                        pix_since = 0;
                    end
                end
                if (started) begin
                    d = dec(sh, sv, 4, 5, 7, 3, 4, 5);
                    {svl, shs, svs} = d;
                end else begin
                    svl = 1'b0; shs = 1'b1; svs = 1'b1;
                end
                chk("small.h_cnt", int'(h_b), sh);
                chk("small.v_cnt", int'(v_b), sv);
                chk("small.valid", int'(vld_b), int'(svl));
                chk("small.hsync", int'(hs_b), int'(shs));
                chk("small.vsync", int'(vs_b), int'(svs));
                chk("small.line_start", int'(ls_b), int'(sls));
                chk("small.frame_start", int'(fs_b), int'(sfs));
                chk("small.frame_cnt", int'(fc_b), fc_exp);
            end
            chk("small.wraps_reached", wraps, 257);
`ifdef VGA_FRAME_CNT_EN
            chk("small.frame_cnt_final", int'(fc_b), 1);
`else
            chk("small.frame_cnt_final", int'(fc_b), 0);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
